// File: rtl/cont_enable_ctrl_pkg.sv
// Shared definitions for the counter control stage: run FSM encoding and
// board-level timing defaults (50 MHz clock).
package cont_enable_ctrl_pkg;

    // Run FSM encoding
    localparam logic [0:0] STOP = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // 50 MHz -> 1 Hz enable tick
    localparam int unsigned PRESCALE_1HZ = 50000000;
    // 20 ms button debounce at 50 MHz
    localparam int unsigned DEB_20MS     = 1000000;

endpackage

// File: rtl/cont_enable_ctrl_if.sv
// Button/counter-side signal bundle of the control stage.
// master = the board/bench side that drives buttons and tc, slave = the control block.
interface cont_enable_ctrl_if;
    logic run_btn;
    logic dir_btn;
    logic tc_in;
    logic enable;
    logic updown;
    logic running;

    modport master (
        output run_btn,
        output dir_btn,
        output tc_in,
        input  enable,
        input  updown,
        input  running
    );

    modport slave (
        input  run_btn,
        input  dir_btn,
        input  tc_in,
        output enable,
        output updown,
        output running
    );
endinterface

// File: rtl/cont_enable_ctrl_debounce_pulse.sv
// Pushbutton conditioner: 2-FF synchronizer, stability debounce and a
// one-cycle pulse on every accepted press (rising edge of the debounced level).
module debounce_pulse
    import cont_enable_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_20MS
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int unsigned    CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          level_reg;
    logic          level_d_reg;

    // Synchronize, then accept a new level only after DEB_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], btn};
            level_d_reg <= level_reg;
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // this sample is the DEB_CYCLES-th stable one: commit it
                level_reg <= sync_reg[1];
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    // Press pulse only on the 0->1 transition; releases are silent.
    assign press = level_reg & ~level_d_reg;

endmodule

// File: rtl/cont_enable_ctrl.sv
// Control stage in front of the 4-bit up/down counter: debounced run/stop and
// direction buttons, a prescaled one-cycle enable tick while running, and an
// optional stop when the counter reports terminal count.
module cont_enable_ctrl
    import cont_enable_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE   = PRESCALE_1HZ,
    parameter int unsigned DEB_CYCLES = DEB_20MS,
    parameter bit          STOP_ON_TC = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    cont_enable_ctrl_if.slave  bus
);
    localparam int unsigned   PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [1:0]    btn_vec;
    logic [1:0]    press_vec;
    logic          run_press;
    logic          dir_press;
    logic          tc_stop;

    logic [0:0]    state_reg;
    logic [0:0]    state_next;
    logic [PW-1:0] ps_cnt_reg;
    logic [PW-1:0] ps_cnt_next;
    logic          enable_reg;
    logic          enable_next;
    logic          updown_reg;

    // index 0 = run/stop button, index 1 = direction button
    assign btn_vec = {bus.dir_btn, bus.run_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            debounce_pulse #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_vec[gi]),
                .press (press_vec[gi])
            );
        end
    endgenerate

    assign run_press = press_vec[0];
    assign dir_press = press_vec[1];
    assign tc_stop   = STOP_ON_TC && bus.tc_in;

    // Run FSM next state; a run press together with tc still ends in STOP.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STOP:    if (run_press)            state_next = RUN;
            RUN:     if (run_press || tc_stop) state_next = STOP;
            default:                           state_next = STOP;
        endcase
    end

    // Prescaler advances only while staying in RUN; entering or leaving RUN
    // zeroes it, and a tick that would land as RUN is left is dropped.
    always_comb begin
        ps_cnt_next = '0;
        enable_next = 1'b0;
        if (state_reg == RUN && state_next == RUN) begin
            enable_next = (ps_cnt_reg == PS_LAST);
            ps_cnt_next = (ps_cnt_reg == PS_LAST) ? '0 : ps_cnt_reg + PW'(1);
        end
    end

    // Register FSM state, prescale count and the enable tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= STOP;
            ps_cnt_reg <= '0;
            enable_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ps_cnt_reg <= ps_cnt_next;
            enable_reg <= enable_next;
        end
    end

    // Direction flips on every accepted dir press, independent of run state.
    always_ff @(posedge clk) begin
        if (reset) begin
            updown_reg <= 1'b1;
        end else if (dir_press) begin
            updown_reg <= ~updown_reg;
        end
    end

    assign bus.enable  = enable_reg;
    assign bus.updown  = updown_reg;
    assign bus.running = (state_reg == RUN);

endmodule

// File: tb/tb_cont_enable_ctrl.sv
// Scoreboard bench for cont_enable_ctrl: a reference model predicts output
// events (running/updown changes, enable ticks with their direction) and a
// negedge monitor matches what the DUT shows against that queue.
module tb_cont_enable_ctrl;
    localparam int P   = 4;
    localparam int DEB = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cont_enable_ctrl_if bus();

    cont_enable_ctrl #(
        .PRESCALE   (P),
        .DEB_CYCLES (DEB),
        .STOP_ON_TC (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream 4-bit up/down counter; tc only reaches the DUT when gated on.
    logic [3:0] q;
    logic       tc_gate;
    logic       tc_raw;
    always @(posedge clk) begin
        if (reset)           q <= 4'h0;
        else if (bus.enable) q <= bus.updown ? q + 4'h1 : q - 4'h1;
    end
    assign tc_raw    = bus.enable && (bus.updown ? (q == 4'hF) : (q == 4'h0));
    assign bus.tc_in = tc_gate && tc_raw;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // kind: 0 = running change, 1 = updown change, 2 = enable tick (val = updown)
    typedef struct {
        int kind;
        bit val;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    // ---------------- reference model ----------------
    // Button acceptance: level flips once the last DEB synchronized samples
    // (raw samples 2..DEB+1 edges old) all disagree with it.
    logic [DEB+1:0] m_hist [2];
    logic [DEB-1:0] m_win;
    bit [1:0] m_lvl, m_pend;
    bit m_run, n_run, m_en, m_upd, m_flip;
    bit e_run = 1'b0, e_upd = 1'b1;
    int m_t;

    always @(posedge clk) begin
        if (started) begin
            if (reset) begin
                m_hist[0] = '0; m_hist[1] = '0;
                m_lvl = '0; m_pend = '0;
                m_run = 1'b0; m_t = 0; m_en = 1'b0; m_upd = 1'b1;
            end else begin
                n_run = m_run;
                if (m_run) begin
                    if (m_pend[0] || bus.tc_in) n_run = 1'b0;
                end else if (m_pend[0]) begin
                    n_run = 1'b1;
                end
                m_en = 1'b0;
                if (m_run && n_run) begin
                    m_t++;
                    m_en = (m_t % P == 0);
                end else begin
                    m_t = 0;
                end
                m_run = n_run;
                if (m_pend[1]) m_upd = ~m_upd;
                for (int b = 0; b < 2; b++) begin
                    m_hist[b] = {m_hist[b][DEB:0], (b == 0) ? bus.run_btn : bus.dir_btn};
                    m_win  = m_hist[b][DEB+1:2];
                    m_flip = m_lvl[b] ? (m_win == '0) : (m_win == '1);
                    m_pend[b] = m_flip && !m_lvl[b];
                    if (m_flip) m_lvl[b] = ~m_lvl[b];
                end
            end
            if (m_run != e_run) exp_q.push_back('{0, m_run, cyc + 1});
            if (m_upd != e_upd) exp_q.push_back('{1, m_upd, cyc + 1});
            if (m_en)           exp_q.push_back('{2, m_upd, cyc + 1});
            e_run = m_run;
            e_upd = m_upd;
        end
    end

    // ---------------- monitor ----------------
    logic a_run = 1'b0, a_upd = 1'b1;
    ev_t  got;

    task automatic check_ev(input int kind, input bit val);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL ev_unexpected cyc=%0d got kind=%0d val=%0b, none expected", cyc, kind, val);
        end else begin
            got = exp_q.pop_front();
            if (got.kind != kind || got.val != val || got.cyc != cyc) begin
                bad++;
                $display("FAIL ev_match got kind=%0d val=%0b cyc=%0d, want kind=%0d val=%0b cyc=%0d",
                         kind, val, cyc, got.kind, got.val, got.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL ev_missing cyc=%0d got nothing, want kind=%0d val=%0b", exp_q[0].cyc, exp_q[0].kind, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (bus.running !== a_run) begin
                check_ev(0, bus.running);
                a_run = bus.running;
            end
            if (bus.updown !== a_upd) begin
                check_ev(1, bus.updown);
                a_upd = bus.updown;
            end
            if (bus.enable !== 1'b0) check_ev(2, bus.updown);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == 0) bus.run_btn = v;
        else        bus.dir_btn = v;
    endtask

    task automatic press(input int b, input int len);
        set_btn(b, 1'b1);
        tick_n(len);
        set_btn(b, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %0s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic check_reset();
        chk("rst_enable",  int'(bus.enable),  0);
        chk("rst_updown",  int'(bus.updown),  1);
        chk("rst_running", int'(bus.running), 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick_n(n);
        reset = 1'b0;
        check_reset();
    endtask

    int ticks, tcs, guard, b, len;

    initial begin
        bus.run_btn = 1'b0;
        bus.dir_btn = 1'b0;
        tc_gate     = 1'b0;
        started     = 1'b1;

        // 1: reset, then idle with no buttons
        do_reset(3);
        tick_n(50);

        // 2: clean run press held 10 cycles
        press(0, 10);
        tick_n(25);

        // 3: stop, then glitches of 1 and 2 cycles, then a 3-cycle press, then release bounce
        press(0, 6);
        tick_n(10);
        press(0, 1); tick_n(6);
        press(0, 2); tick_n(6);
        press(0, 3); tick_n(8);
        press(0, 1); tick_n(1);
        press(0, 2); tick_n(1);
        press(0, 1); tick_n(12);

        // 4: direction presses while running
        press(1, 5); tick_n(12);
        press(1, 5); tick_n(12);

        // 5: stop on terminal count, counting up from 0
        do_reset(2);
        tc_gate = 1'b1;
        press(0, 4);
        guard = 0;
        while (bus.running !== 1'b1 && guard < 50) begin
            tick_n(1);
            guard++;
        end
        chk("t5_run_start", int'(bus.running), 1);
        ticks = 0; tcs = 0; guard = 0;
        while (bus.running === 1'b1 && guard < 200) begin
            if (bus.enable) ticks++;
            if (bus.tc_in)  tcs++;
            tick_n(1);
            guard++;
        end
        chk("t5_ticks", ticks, 16);
        chk("t5_tc_pulses", tcs, 1);
        ticks = 0;
        repeat (12) begin
            if (bus.enable) ticks++;
            tick_n(1);
        end
        chk("t5_after_stop_ticks", ticks, 0);
        tc_gate = 1'b0;

        // 6: reset mid-count and mid-debounce of a dir press
        press(0, 4);
        tick_n(9);
        bus.dir_btn = 1'b1;
        tick_n(3);
        bus.dir_btn = 1'b0;
        do_reset(1);
        tick_n(20);
        press(1, 4); tick_n(10);
        // button held through reset deassertion is a press
        bus.dir_btn = 1'b1;
        do_reset(1);
        tick_n(10);
        bus.dir_btn = 1'b0;
        tick_n(10);

        // randomized mix of presses, glitches, tc and resets
        for (int i = 0; i < 60; i++) begin
            b   = int'($urandom_range(1, 0));
            len = int'($urandom_range(7, 1));
            tc_gate = ($urandom_range(3, 0) == 0);
            press(b, len);
            tick_n(int'($urandom_range(10, 1)));
            if ($urandom_range(19, 0) == 0) begin
                reset = 1'b1;
                tick_n(int'($urandom_range(2, 1)));
                reset = 1'b0;
            end
        end
        tc_gate = 1'b0;
        tick_n(10);

        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL ev_missing_end got nothing, want kind=%0d val=%0b cyc=%0d", exp_q[0].kind, exp_q[0].val, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
